// File: rtl/alu_pkg.sv
// Shared opcode encodings and command layout for the ALU and its issue unit.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;
    localparam int CMD_W  = OP_W + DATA_W + DATA_W + 1;

    localparam logic [OP_W-1:0] ALU_AND     = 4'd0;
    localparam logic [OP_W-1:0] ALU_OR      = 4'd1;
    localparam logic [OP_W-1:0] ALU_XOR     = 4'd2;
    localparam logic [OP_W-1:0] ALU_ADD     = 4'd3;
    localparam logic [OP_W-1:0] ALU_SUB     = 4'd4;
    localparam logic [OP_W-1:0] ALU_MUL     = 4'd5;
    localparam logic [OP_W-1:0] ALU_EQ      = 4'd6;
    localparam logic [OP_W-1:0] ALU_NE      = 4'd7;
    localparam logic [OP_W-1:0] ALU_GE      = 4'd8;
    localparam logic [OP_W-1:0] ALU_GT      = 4'd9;
    localparam logic [OP_W-1:0] ALU_LT      = 4'd10;
    localparam logic [OP_W-1:0] ALU_LE      = 4'd11;
    localparam logic [OP_W-1:0] ALU_SLL     = 4'd12;
    localparam logic [OP_W-1:0] ALU_SRL     = 4'd13;
    localparam logic [OP_W-1:0] ALU_SRA     = 4'd14;
    localparam logic [OP_W-1:0] ALU_ILLEGAL = 4'd15;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              chain;
    } alu_cmd_t;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op != ALU_ILLEGAL);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; compares are signed, shifts use b[4:0], unknown opcodes give 0.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Opcode decode
    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_MUL: result = a * b;
            ALU_EQ:  result = {31'd0, (a == b)};
            ALU_NE:  result = {31'd0, (a != b)};
            ALU_GE:  result = {31'd0, ($signed(a) >= $signed(b))};
            ALU_GT:  result = {31'd0, ($signed(a) >  $signed(b))};
            ALU_LT:  result = {31'd0, ($signed(a) <  $signed(b))};
            ALU_LE:  result = {31'd0, ($signed(a) <= $signed(b))};
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_issue_unit_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer and occupancy tracking; storage itself needs no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/alu_issue_unit.sv
// Buffers ALU commands, drives the combinational ALU from the FIFO head and
// captures the result into a valid/ready response register with operand chaining.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  op_count
);

    localparam int FC_W = $clog2(DEPTH) + 1;

    alu_cmd_t          w_cmd_in;
    alu_cmd_t          w_head;
    logic [CMD_W-1:0]  w_head_vec;
    logic [FC_W-1:0]   w_fifo_count;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_issue;
    logic              w_legal;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_illegal;
    logic [DATA_W-1:0] r_last_result;
    logic [CNT_W-1:0]  r_op_count;

    assign w_cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b, chain: cmd_chain};
    // Readiness looks only at occupancy, never at a same-cycle pop.
    assign cmd_ready = (w_fifo_count < FC_W'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;
    assign w_issue   = !w_fifo_empty && (!r_rsp_valid || rsp_ready);
    assign w_head    = alu_cmd_t'(w_head_vec);
    assign w_legal   = is_legal(w_head.op);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_cmd_in),
        .pop   (w_issue),
        .dout  (w_head_vec),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // ALU operand drive from FIFO head; chaining resolves against the last legal result
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!w_fifo_empty) begin
            alu_op = w_head.op;
            alu_b  = w_head.b;
            alu_a  = w_head.chain ? r_last_result : w_head.a;
        end else begin
            alu_op = '0;
        end
    end

    // Response register: load on issue, clear on handshake without a replacement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (w_issue) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= w_legal ? alu_result : '0;
            r_rsp_zero    <= w_legal ? alu_zero : 1'b0;
            r_rsp_illegal <= !w_legal;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    // Chaining source and issued-op counter advance only on legal issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_result <= '0;
            r_op_count    <= '0;
        end else if (w_issue && w_legal) begin
            r_last_result <= alu_result;
            r_op_count    <= r_op_count + CNT_W'(1);
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;
    assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit driving the real alu; expectations come
// from an in-order reference model evaluated when each command is accepted.
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [31:0]       cmd_a;
    logic [31:0]       cmd_b;
    logic              cmd_chain;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_op;
    logic [31:0]       alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_illegal;
    logic [CNT_W-1:0]  op_count;

    always #5 clk = ~clk;

    alu_issue_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .op_count(op_count)
    );

    alu u_alu (
        .a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result), .zero(alu_zero)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_last;
    int          m_pop_legal;
    logic        m_rand_rdy;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_hs = -100;
    int          prev_hs = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sx;
        int signed sy;
        sx = a;
        sy = b;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a ^ b;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd5:  return a * b;
            4'd6:  return (a == b) ? 32'd1 : 32'd0;
            4'd7:  return (a != b) ? 32'd1 : 32'd0;
            4'd8:  return (sx >= sy) ? 32'd1 : 32'd0;
            4'd9:  return (sx >  sy) ? 32'd1 : 32'd0;
            4'd10: return (sx <  sy) ? 32'd1 : 32'd0;
            4'd11: return (sx <= sy) ? 32'd1 : 32'd0;
            4'd12: return a << b[4:0];
            4'd13: return a >> b[4:0];
            4'd14: return sx >>> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Commands issue strictly in order, so the expected response is fixed at acceptance.
    task automatic model_push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic ch);
        exp_t        e;
        logic [31:0] r;
        if (op == 4'd15) begin
            e = '{res: 32'd0, zero: 1'b0, ill: 1'b1};
        end else begin
            r = ref_alu(op, ch ? m_last : a, b);
            m_last = r;
            e = '{res: r, zero: (r == 32'd0), ill: 1'b0};
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ch, output int acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
        acc       = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc + 1;
                model_push(op, a, b, ch);
            end
            @(posedge clk);
            #1;
            if (m_rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted op=%0d", op);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake is compared against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%0h required=none", rsp_result);
            end else begin
                e = sb.pop_front();
                if (!e.ill) m_pop_legal++;
                check("rsp_result",  rsp_result,  e.res);
                check("rsp_zero",    rsp_zero,    e.zero);
                check("rsp_illegal", rsp_illegal, e.ill);
                check("op_count",    op_count,    CNT_W'(m_pop_legal));
            end
            prev_hs = last_hs;
            last_hs = cyc;
        end
    end

    initial begin
        int acc;
        int acc2;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_chain = 1'b0; rsp_ready = 1'b1; m_rand_rdy = 1'b0; m_last = 32'd0; m_pop_legal = 0;
        cycles(2);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", rsp_zero, 1'b0);
        check("rst_rsp_illegal", rsp_illegal, 1'b0);
        check("rst_op_count", op_count, 16'd0);
        check("rst_alu_op", alu_op, 4'd0);
        check("rst_alu_a", alu_a, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic latency: ADD 1+6
        send(4'd3, 32'd1, 32'd6, 1'b0, acc);
        @(negedge clk);
        check("lat_not_early", rsp_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", rsp_valid, 1'b1);
        check("lat_result", rsp_result, 32'd7);
        cycles(2);
        check("latency_cycle", 32'(last_hs), 32'(acc + 1));

        // SUB to zero
        send(4'd4, 32'd100, 32'd100, 1'b0, acc);
        cycles(3);
        check("sub_zero_flag_seen", 32'(m_pop_legal), 32'd2);

        // Chained MUL then SRL, back to back
        send(4'd5, 32'd25, 32'd520843, 1'b0, acc);
        send(4'd13, 32'hDEAD_BEEF, 32'd5, 1'b1, acc2);
        check("chain_accept_b2b", 32'(acc2), 32'(acc + 1));
        cycles(4);
        check("chain_rsp_b2b", 32'(last_hs - prev_hs), 32'd1);

        // Backpressure: five accepted, sixth refused
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'd1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, acc);
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_a = 32'hFFFF_0000; cmd_b = 32'h0000_FFFF; cmd_chain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_cmd_ready", cmd_ready, 1'b0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_stable", rsp_result, 32'hFFFF_FFFF);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_valid", rsp_valid, 1'b1);
        end
        @(negedge clk);
        check("drain_done", rsp_valid, 1'b0);
        @(posedge clk); #1;

        // Illegal opcode between AND and chained XOR
        ra = $urandom; rb = $urandom;
        send(4'd0, ra, rb, 1'b0, acc);
        send(4'd15, $urandom, $urandom, 1'b0, acc);
        send(4'd2, 32'd0, $urandom, 1'b1, acc);
        cycles(6);
        check("illegal_opcount", op_count, CNT_W'(m_pop_legal));
        check("illegal_legal_total", 32'(m_pop_legal), 32'd11);

        // Reset with three queued commands and a held response
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'd3, $urandom, $urandom, 1'b0, acc);
        rst = 1'b1;
        sb.delete();
        m_last = 32'd0;
        m_pop_legal = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_op_count", op_count, 16'd0);
        check("mid_rst_alu_op", alu_op, 4'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        cycles(10);
        check("mid_rst_no_stale", 32'(last_hs < cyc - 9), 32'd1);

        // Randomized traffic with random response backpressure
        m_rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            send(rop, ra, rb, 1'($urandom_range(0, 2) == 0), acc);
        end
        m_rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) cycles(1);
        cycles(2);
        check("final_drain", 32'(sb.size()), 32'd0);
        check("final_op_count", op_count, CNT_W'(m_pop_legal));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
